serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised digit-serial adder/subtractor; successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using one DIGIT-bit adder slice and an internal carry flop.
- Start/busy/done handshake; the result is registered and held until the next operation completes.
- Used in area-constrained datapaths where latency is traded for adder width.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly; N = WIDTH/DIGIT.

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  request; sampled on rising edge.
- sub_in  input  1  0 = add, 1 = subtract; captured with the operands.
- a_in  input  WIDTH  operand A; captured on an accepted start.
- b_in  input  WIDTH  operand B; captured on an accepted start.
- c_in  input  1  carry-in (add) or borrow-in (subtract); captured on an accepted start.
- busy_out  output  1  high while in RUN.
- done_out  output  1  one-cycle completion pulse.
- sum_out  output  WIDTH  registered result.
- carry_out  output  1  raw carry out of the MSB.
- overflow_out  output  1  two's-complement signed overflow.

Behaviour:
- Reset (asynchronous, rst_n_in = 0):
  - state goes to IDLE immediately.
  - All outputs are 0: sum_out, carry_out, overflow_out, busy_out, done_out.
  - Digit counter, operand registers and carry flop are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_in = 1 at an edge → capture operands, go to RUN, counter = 0.
  - Operand capture loads a_in, b_in, sub_in and c_in.
  - Carry flop init: c_in for add; ~c_in for subtract.
- RUN, one digit per edge, starting with the LS digit:
  - Digit i = bits [i*DIGIT +: DIGIT].
  - B digit is used as-is for add, inverted for subtract.
  - Result digit = A digit + B digit + carry flop. Store the digit result and update the carry flop.
  - Capture the carry into the MSB position for overflow detection.
  - start_in is ignored; busy_out = 1.
  - After the N-th RUN edge (counter = N-1): go to DONE and update sum_out, carry_out and overflow_out on that same edge.
- DONE (lasts exactly one cycle):
  - done_out = 1, busy_out = 0.
  - Next state is IDLE, or RUN if start_in = 1 (back-to-back start is accepted in DONE).
- Latency: start accepted at edge 0 → done_out and results visible after edge N. Throughput is one operation per N+1 cycles.
- Arithmetic:
  - Add: {carry_out, sum_out} = a + b + c_in.
  - Subtract: {carry_out, sum_out} = a + ~b + ~c_in, i.e. a − b − c_in. carry_out = 1 means no borrow.
  - overflow_out = carry into MSB XOR carry out of MSB.
- Held results: sum_out, carry_out and overflow_out hold their last values until the next completion. Intermediate digits are never visible.
- Input stability: a_in, b_in, sub_in and c_in may change freely after capture without affecting the operation in progress.
- Reset mid-RUN: the operation is aborted; no done_out is produced; outputs read 0.
- DIGIT = WIDTH (N = 1): single RUN cycle, done after edge 1.

Test Plan:
- Add, W=8 D=1: a=FF, b=01, c=0, sub=0 → after 8 edges: done pulse, sum=00, carry=1, ovf=0; busy high for 8 cycles.
- Signed overflow, add: a=7F, b=01, c=0 → sum=80, carry=0, ovf=1.
- Subtract: a=05, b=07, c=0, sub=1 → sum=FE, carry=0, ovf=0.
- Subtract with overflow: a=80, b=01 → sum=7F, carry=1, ovf=1.
- start_in held high across RUN with changing a_in, b_in: no re-capture; result = first operands.
- Back-to-back:
  - start asserted in the DONE cycle → second RUN begins with no IDLE cycle.
  - The second op's operands are captured at that edge; its done arrives N+1 cycles after the first done.
- Reset during RUN: rst_n_in low at counter=3 → all outputs 0 immediately; no done after release; the next start completes correctly.
- W=8 D=4: a=3C, b=C4, c=1 → done after 2 edges, sum=01, carry=1, ovf=0.
- Exhaustive sweep, W=4 D=2: all a, b, c, sub combinations → compare against a behavioural reference model.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor. Operands are captured on an accepted start and
// processed DIGIT bits per clock through a single DIGIT-bit adder slice, least
// significant digit first, with the inter-digit carry held in a flop. The
// result, carry and signed overflow are registered on the final digit and held
// until the next operation completes.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);

    // Number of digits per operand and the counter that walks them.
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;

    // Captured operands and operation state.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    // Partial result built up digit by digit; never visible on sum_out.
    logic [WIDTH-1:0] r_acc;

    // Held results.
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    int unsigned      w_base;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT:0]   w_slice;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_acc_next;

    // A start is accepted from IDLE and also from DONE (back-to-back operation).
    assign w_accept = start_in && ((r_state == StIdle) || (r_state == StDone));
    assign w_last   = (r_state == StRun) && (r_cnt == LAST);

    // One DIGIT-bit adder slice operating on the digit selected by the counter.
    always_comb begin
        w_base     = 32'(r_cnt) * DIGIT;
        w_a_dig    = r_a[w_base +: DIGIT];
        // Subtraction is a + ~b + ~borrow; the inverted borrow is preloaded into
        // the carry flop at capture time.
        w_b_dig    = r_b[w_base +: DIGIT] ^ {DIGIT{r_sub}};
        w_slice    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
        // Carry into the top bit of this digit, recovered from its sum bit. Only
        // consumed on the last digit, where that bit is the operand MSB.
        w_c_msb    = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_slice[DIGIT-1];
        w_acc_next = r_acc;
        w_acc_next[w_base +: DIGIT] = w_slice[DIGIT-1:0];
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN for N digits -> single-cycle DONE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start_in) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (r_cnt == LAST) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = start_in ? StRun : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Operand capture, per-digit accumulation and result registration.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_sub   <= sub_in;
            r_carry <= c_in ^ sub_in;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (r_state == StRun) begin
            r_carry <= w_slice[DIGIT];
            r_acc   <= w_acc_next;
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_slice[DIGIT];
                r_ovf  <= w_c_msb ^ w_slice[DIGIT];
            end
        end
    end

    assign busy_out     = (r_state == StRun);
    assign done_out     = (r_state == StDone);
    assign sum_out      = r_sum;
    assign carry_out    = r_cout;
    assign overflow_out = r_ovf;

endmodule
